// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Multi-cycle instruction fetch engine. On a fetch command it issues a word
// read to instruction memory over a req/ack handshake, captures the returned
// word, then presents it to the instruction register with a one-cycle IRWre
// strobe. It also produces PC+4 and reports misaligned-address and
// no-response (timeout) faults.
//
// Handshake: mem_req is held high, with mem_addr constant, for as long as the
// engine is in REQ. A cycle in which mem_req=1 and mem_ack=1 at the rising
// edge transfers mem_rdata; that is the only cycle in which mem_rdata is
// sampled. mem_ack in any other state is ignored.
//
// Ports:
//   CLK          in   1   system clock, all state on posedge
//   RST          in   1   asynchronous active-low reset
//   start_fetch  in   1   fetch command, sampled only in IDLE
//   pc_in        in  32   fetch address, sampled with start_fetch
//   flush        in   1   abort an in-flight fetch / clear a fault
//   mem_req      out  1   read request to instruction memory
//   mem_addr     out 32   read address, stable while mem_req=1
//   mem_ack      in   1   memory acknowledge, mem_rdata valid in same cycle
//   mem_rdata    in  32   instruction word from memory
//   ir_data      out 32   captured instruction word
//   IRWre        out  1   instruction register write enable, one-cycle pulse
//   pc_plus4     out 32   fetched address + 4
//   fetch_done   out  1   one-cycle pulse, coincident with IRWre
//   busy         out  1   high in any state except IDLE
//   fault        out  1   misaligned address or timeout, sticky until flush
//   fsm_state    out  2   current FSM state (debug: 0 IDLE,1 REQ,2 DONE,3 ERR)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT    = 16,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start_fetch,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir_data,
    output logic        IRWre,
    output logic [31:0] pc_plus4,
    output logic        fetch_done,
    output logic        busy,
    output logic        fault,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Counter value of the last REQ cycle that may still accept an ack.
    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] ir_nxt;
    logic [31:0] pp4_nxt;
    logic        req_nxt;
    logic        irwre_nxt;
    logic        busy_nxt;
    logic        fault_nxt;
    logic        accept;

    // An ack is accepted only in REQ and only when no flush races it.
    assign accept    = (state == S_REQ) && mem_ack && !flush;
    assign fsm_state = state;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------- next-state comb
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (start_fetch) begin
                    state_nxt = (pc_in[1:0] == 2'b00) ? S_REQ : S_ERR;
                end
            end
            S_REQ: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (mem_ack) begin
                    state_nxt = S_DONE;
                end else if (cnt >= LAST_CNT) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- output comb
    // Every output is registered, so this block computes the values the
    // output registers take at the next edge, derived from the next state.
    always_comb begin
        req_nxt   = (state_nxt == S_REQ);
        irwre_nxt = (state_nxt == S_DONE);
        busy_nxt  = (state_nxt != S_IDLE);
        fault_nxt = (state_nxt == S_ERR);

        addr_nxt = mem_addr;
        ir_nxt   = ir_data;
        pp4_nxt  = pc_plus4;
        cnt_nxt  = cnt;

        if (state == S_IDLE && start_fetch) begin
            addr_nxt = pc_in;
            cnt_nxt  = 8'd0;
        end
        if (state == S_REQ && !mem_ack) begin
            cnt_nxt = cnt + 8'd1;
        end
        if (accept) begin
            ir_nxt  = mem_rdata;
            pp4_nxt = mem_addr + 32'd4;   // wraps modulo 2^32
        end
    end

    // --------------------------------------------------------- output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_req    <= 1'b0;
            mem_addr   <= RESET_ADDR;
            ir_data    <= 32'd0;
            IRWre      <= 1'b0;
            fetch_done <= 1'b0;
            pc_plus4   <= RESET_ADDR + 32'd4;
            busy       <= 1'b0;
            fault      <= 1'b0;
            cnt        <= 8'd0;
        end else begin
            mem_req    <= req_nxt;
            mem_addr   <= addr_nxt;
            ir_data    <= ir_nxt;
            IRWre      <= irwre_nxt;
            fetch_done <= irwre_nxt;
            pc_plus4   <= pp4_nxt;
            busy       <= busy_nxt;
            fault      <= fault_nxt;
            cnt        <= cnt_nxt;
        end
    end

endmodule
